instr_fetch_unit: RTL and testbench

//  Fetch stage upstream of the instruction field decoder. Holds the PC and issues

---
 rtl/instr_fetch_unit.sv | 131 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, issues word-aligned requests to instruction memory
// under a credit limit, buffers in-order responses with their PCs, and presents
// them to decode. A redirect restarts fetch at a new PC and drops every response
// still owed for the old path.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {FETCH, FLUSH} state_t;

  state_t state, state_next;

  logic          run;
  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [31:0]   inst_pc_q;
  logic [31:0]   redirect_target;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] drop_cnt, drop_cnt_next;
  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   fifo_data [FIFO_DEPTH];
  logic [31:0]   fifo_pc   [FIFO_DEPTH];
  logic          credit, req_fire, rsp_accept, rsp_drop, push, pop;

  assign redirect_target = redirect_pc & ~32'h3;
  assign occupancy       = {1'b0, inflight} + {1'b0, count};
  assign credit          = occupancy < (CW + 1)'(FIFO_DEPTH);
  assign req_fire        = imem_req_valid && imem_req_ready;
  assign rsp_accept      = imem_rsp_valid && (inflight != '0);
  assign push            = rsp_accept && !rsp_drop;
  assign pop             = inst_valid && inst_ready && !redirect_valid;
  assign inflight_next   = inflight + CW'(req_fire) - CW'(rsp_accept);
  assign imem_req_addr   = pc;

  // State register: FLUSH while responses from an abandoned path are still owed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_next;
  end

  // Next state and drop count: a redirect re-arms the drop count from what is still owed.
  always_comb begin
    state_next    = state;
    drop_cnt_next = drop_cnt;
    if (redirect_valid) begin
      drop_cnt_next = inflight_next;
      state_next    = (inflight_next != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH) begin
      if (rsp_accept) drop_cnt_next = drop_cnt - CW'(1);
      if (drop_cnt_next == '0) state_next = FETCH;
    end
  end

  // Outputs: request gating by credit, response dropping, and the decode-facing head.
  always_comb begin
    imem_req_valid = run && !redirect_valid && credit;
    rsp_drop       = redirect_valid || (state == FLUSH);
    inst_valid     = (count != '0);
    inst           = NOP;
    inst_pc        = inst_pc_q;
    if (count != '0) begin
      inst    = fifo_data[rd_ptr];
      inst_pc = fifo_pc[rd_ptr];
    end
  end

  // PC, credit counters and fifo pointers; a redirect flushes the buffer outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run       <= 1'b0;
      pc        <= RESET_PC;
      rsp_pc    <= RESET_PC;
      inst_pc_q <= '0;
      inflight  <= '0;
      drop_cnt  <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      run       <= 1'b1;
      inst_pc_q <= inst_pc;
      inflight  <= inflight_next;
      drop_cnt  <= drop_cnt_next;
      if (redirect_valid) begin
        pc     <= redirect_target;
        rsp_pc <= redirect_target;
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (req_fire) pc <= pc + 32'd4;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Buffer storage: responses on the live path are sequential, so rsp_pc names each one.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= rsp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a random memory and decode environment, a program-order
// reference model that predicts request addresses, credit use and the instruction
// stream, and a monitor that checks what decode sees against the predicted stream.
module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic        stale;
  } req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid, inst_ready = 1'b0;
  logic [31:0] inst, inst_pc;

  req_t        mq[$];
  exp_t        expq[$];
  logic [31:0] model_pc = RESET_PC;
  bit          model_on = 1'b0;
  bit          pop_now  = 1'b0;
  int          total = 0;
  int          bad   = 0;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: whatever decode sees must be the oldest predicted instruction.
  initial begin
    forever begin
      @(negedge clk);
      pop_now = 1'b0;
      if (model_on && rst_n) begin
        checkOutput("inst_valid", {31'b0, inst_valid}, {31'b0, expq.size() != 0});
        if (inst_valid && expq.size() != 0) begin
          checkOutput("inst_pc", inst_pc, expq[0].pc);
          checkOutput("inst", inst, expq[0].data);
          if (inst_ready && !redirect_valid) begin
            expq.delete(0);
            pop_now = 1'b1;
          end
        end
      end
    end
  end

  // Reference model: program order, credits and redirect semantics at transaction level.
  initial begin
    int occ;
    req_t r;
    forever begin
      @(negedge clk);
      #1;
      if (model_on && rst_n) begin
        occ = mq.size() + expq.size() + (pop_now ? 1 : 0);
        checkOutput("req_valid", {31'b0, imem_req_valid},
                    {31'b0, (!redirect_valid && occ < FIFO_DEPTH)});
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("req_addr", imem_req_addr, model_pc);
          mq.push_back('{pc: model_pc, stale: 1'b0});
          model_pc = model_pc + 32'd4;
        end
        if (imem_rsp_valid && mq.size() != 0) begin
          r = mq.pop_front();
          if (!r.stale && !redirect_valid)
            expq.push_back('{pc: r.pc, data: r.pc ^ 32'h0000_00A5});
        end
        if (redirect_valid) begin
          foreach (mq[i]) mq[i].stale = 1'b1;
          expq.delete();
          model_pc = {redirect_pc[31:2], 2'b00};
        end
      end
    end
  end

  // One cycle of environment behaviour: memory handshakes, decode back-pressure, redirects.
  task automatic applyStimulus(input int pr, input int prsp, input int predir, input int pinst,
                               input logic [31:0] target, input bit rnd_target);
    @(posedge clk);
    #2;
    imem_req_ready = ($urandom_range(99) < pr);
    inst_ready     = ($urandom_range(99) < pinst);
    redirect_valid = ($urandom_range(99) < predir);
    redirect_pc    = rnd_target ? $urandom : target;
    if (mq.size() != 0 && $urandom_range(99) < prsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq[0].pc ^ 32'h0000_00A5;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  // Reset pulse: outputs must reach reset values in the same cycle, before any clock edge.
  task automatic applyReset();
    @(posedge clk);
    #2;
    model_on       = 1'b0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    mq.delete();
    expq.delete();
    model_pc = RESET_PC;
    #1;
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_inst", inst, 32'h0000_0013);
    checkOutput("rst_inst_pc", inst_pc, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2 model_on = 1'b1;
  endtask

  initial begin
    applyReset();
    repeat (40) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    repeat (20) applyStimulus(100, 100, 0, 0, 32'd0, 1'b0);
    repeat (20) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    repeat (5)  applyStimulus(0, 100, 0, 100, 32'd0, 1'b0);
    repeat (10) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    repeat (2)  applyStimulus(100, 0, 0, 100, 32'd0, 1'b0);
    applyStimulus(100, 0, 100, 100, 32'h0000_0103, 1'b0);
    repeat (20) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    applyStimulus(100, 100, 100, 100, 32'hFFFF_FFF7, 1'b0);
    repeat (20) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    repeat (1500) applyStimulus(60, 50, 5, 60, 32'd0, 1'b1);
    repeat (40) applyStimulus(70, 60, 0, 50, 32'd0, 1'b0);
    applyReset();
    repeat (500) applyStimulus(60, 50, 8, 60, 32'd0, 1'b1);
    repeat (30) applyStimulus(100, 100, 0, 100, 32'd0, 1'b0);
    repeat (20) applyStimulus(0, 100, 0, 100, 32'd0, 1'b0);
    @(negedge clk);
    #2;
    checkOutput("drain_inflight", mq.size(), 32'd0);
    checkOutput("drain_buffer", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
